// File: rtl/wdt_ctrl_pkg.sv
// Shared definitions for the watchdog reset controller.
// Contents: controller state encoding, DRT counter width and a helper that
// returns the terminal DRT count for a given hold length.
package wdt_ctrl_pkg;

  // Controller states. HOLD keeps the core in reset, RUN is normal
  // execution and SLEEP is the halted low-power state.
  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SLEEP = 2'd2
  } state_t;

  // Width of the device reset timer counter; covers hold lengths up to 255.
  localparam int DRT_W = 8;

  // Last count value of a HOLD period lasting 'cycles' clk_wdt cycles.
  function automatic logic [DRT_W-1:0] drt_last(input int cycles);
    return DRT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/wdt_reset_ctrl_req_sync.sv
// Asynchronous request synchroniser with rising-edge detection.
// Ports: clk_wdt/rst (sync, active-high), i_async (async level in),
//        o_level (synchronised level), o_edge (1-cycle pulse on a 0->1 of o_level).
module req_sync
  import wdt_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_wdt,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_edge
);

  // r_sync[0] is the first (metastability-exposed) stage; the MSB is the
  // stable synchronised level.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  always_ff @(posedge clk_wdt) begin
    if (rst) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_edge  = r_sync[SYNC_STAGES-1] & ~r_level_d;

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Watchdog reset controller: device reset timer, SLEEP/wake sequencing and
// the STATUS TO/PD bits, all in the clk_wdt domain.
// Ports: clk_wdt, rst (sync, active-high); i_wdt_en, i_wdt_timeout (clk_wdt-aligned);
//        i_clrwdt_req, i_sleep_req, i_ext_wake (async, synchronised here);
//        o_clrwdt_ack, o_sleep_ack (4-phase acks), o_wdt_clr, o_cpu_rst,
//        o_sleeping, o_wake (1-cycle pulse), o_status_to, o_status_pd.
module wdt_reset_ctrl
  import wdt_ctrl_pkg::*;
#(
  parameter int DRT_CYCLES  = 18,  // core reset hold length, 2..255
  parameter int SYNC_STAGES = 2    // synchroniser depth, >= 2
) (
  input  logic clk_wdt,
  input  logic rst,
  input  logic i_wdt_en,
  input  logic i_wdt_timeout,
  input  logic i_clrwdt_req,
  input  logic i_sleep_req,
  input  logic i_ext_wake,
  output logic o_clrwdt_ack,
  output logic o_sleep_ack,
  output logic o_wdt_clr,
  output logic o_cpu_rst,
  output logic o_sleeping,
  output logic o_wake,
  output logic o_status_to,
  output logic o_status_pd
);

  localparam logic [DRT_W-1:0] DRT_LAST = drt_last(DRT_CYCLES);

  state_t           r_state;
  logic [DRT_W-1:0] r_drt_cnt;
  logic             r_wdt_prev;
  logic             r_wdt_clr;
  logic             r_status_to;
  logic             r_status_pd;
  logic             r_sleeping;
  logic             r_wake;
  logic             r_clrwdt_ack;
  logic             r_sleep_ack;

  logic w_clr_lvl;
  logic w_clr_edge;
  logic w_slp_lvl;
  logic w_slp_edge;
  logic w_ewk_lvl;
  logic w_ewk_edge_unused;  // wake is level-sensitive; the edge is not needed
  logic w_toe;

  req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clrwdt (
    .clk_wdt (clk_wdt),
    .rst     (rst),
    .i_async (i_clrwdt_req),
    .o_level (w_clr_lvl),
    .o_edge  (w_clr_edge)
  );

  req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sleep (
    .clk_wdt (clk_wdt),
    .rst     (rst),
    .i_async (i_sleep_req),
    .o_level (w_slp_lvl),
    .o_edge  (w_slp_edge)
  );

  req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wake (
    .clk_wdt (clk_wdt),
    .rst     (rst),
    .i_async (i_ext_wake),
    .o_level (w_ewk_lvl),
    .o_edge  (w_ewk_edge_unused)
  );

  // Timeout is acted on only at its rising edge, and only when enabled.
  assign w_toe = i_wdt_timeout & ~r_wdt_prev & i_wdt_en;

  always_ff @(posedge clk_wdt) begin
    if (rst) begin
      r_state      <= ST_HOLD;
      r_drt_cnt    <= '0;
      r_wdt_prev   <= 1'b0;
      r_wdt_clr    <= 1'b1;
      r_status_to  <= 1'b1;
      r_status_pd  <= 1'b1;
      r_sleeping   <= 1'b0;
      r_wake       <= 1'b0;
      r_clrwdt_ack <= 1'b0;
      r_sleep_ack  <= 1'b0;
    end else begin
      r_wdt_prev <= i_wdt_timeout;
      r_wake     <= 1'b0;

      // Acks follow the handshake in every state, even while the request
      // itself is being ignored, so the requester never stalls.
      if (w_clr_edge) begin
        r_clrwdt_ack <= 1'b1;
      end else if (!w_clr_lvl) begin
        r_clrwdt_ack <= 1'b0;
      end
      if (w_slp_edge) begin
        r_sleep_ack <= 1'b1;
      end else if (!w_slp_lvl) begin
        r_sleep_ack <= 1'b0;
      end

      case (r_state)
        ST_HOLD: begin
          // wdt_clr stays high for the whole hold and drops together with
          // the move to RUN.
          if (r_drt_cnt == DRT_LAST) begin
            r_drt_cnt <= '0;
            r_state   <= ST_RUN;
            r_wdt_clr <= 1'b0;
          end else begin
            r_drt_cnt <= r_drt_cnt + DRT_W'(1);
            r_wdt_clr <= 1'b1;
          end
        end

        ST_RUN: begin
          if (w_toe) begin
            // Watchdog reset: PD keeps its value, same-cycle requests dropped.
            r_status_to <= 1'b0;
            r_wdt_clr   <= 1'b1;
            r_drt_cnt   <= '0;
            r_state     <= ST_HOLD;
          end else if (w_slp_edge) begin
            r_wdt_clr   <= 1'b1;
            r_status_to <= 1'b1;
            r_status_pd <= 1'b0;
            r_sleeping  <= 1'b1;
            r_state     <= ST_SLEEP;
          end else if (w_clr_edge) begin
            r_wdt_clr   <= 1'b1;
            r_status_to <= 1'b1;
            r_status_pd <= 1'b1;
          end else begin
            r_wdt_clr <= 1'b0;
          end
        end

        ST_SLEEP: begin
          r_wdt_clr <= 1'b0;
          // A timeout in SLEEP wakes the core instead of resetting it, and
          // takes precedence over an external wake in the same cycle.
          if (w_toe) begin
            r_wake      <= 1'b1;
            r_status_to <= 1'b0;
            r_sleeping  <= 1'b0;
            r_state     <= ST_RUN;
          end else if (w_ewk_lvl) begin
            r_wake     <= 1'b1;
            r_sleeping <= 1'b0;
            r_state    <= ST_RUN;
          end
        end

        default: begin
          // Unreachable encoding: recover through a full reset hold.
          r_state   <= ST_HOLD;
          r_drt_cnt <= '0;
          r_wdt_clr <= 1'b1;
        end
      endcase
    end
  end

  // Core reset decodes straight from the state so it follows HOLD exactly.
  assign o_cpu_rst    = (r_state == ST_HOLD);
  assign o_wdt_clr    = r_wdt_clr;
  assign o_status_to  = r_status_to;
  assign o_status_pd  = r_status_pd;
  assign o_sleeping   = r_sleeping;
  assign o_wake       = r_wake;
  assign o_clrwdt_ack = r_clrwdt_ack;
  assign o_sleep_ack  = r_sleep_ack;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Self-checking bench for wdt_reset_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
// Ports: none (top-level bench).
module tb_wdt_reset_ctrl;

  localparam int DRT  = 18;
  localparam int SYNC = 2;

  logic clk_wdt = 1'b0;
  logic rst, en, tmo, creq, sreq, ewk;
  logic cack, sack, clr, cpu_rst, sleeping, wake, sto, spd;

  always #5 clk_wdt = ~clk_wdt;

  wdt_reset_ctrl #(.DRT_CYCLES(DRT), .SYNC_STAGES(SYNC)) dut (
    .clk_wdt       (clk_wdt),
    .rst           (rst),
    .i_wdt_en      (en),
    .i_wdt_timeout (tmo),
    .i_clrwdt_req  (creq),
    .i_sleep_req   (sreq),
    .i_ext_wake    (ewk),
    .o_clrwdt_ack  (cack),
    .o_sleep_ack   (sack),
    .o_wdt_clr     (clr),
    .o_cpu_rst     (cpu_rst),
    .o_sleeping    (sleeping),
    .o_wake        (wake),
    .o_status_to   (sto),
    .o_status_pd   (spd)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: reset hold is a countdown of remaining cycles, the
  // synchronisers are sample queues, and the sleep flag is a plain boolean.
  int hold_left;
  bit m_asleep, m_to, m_pd, m_clr, m_wake, m_cack, m_sack, m_prev_to;
  bit qc[$], qs[$], qw[$];
  bit pc, ps;

  function automatic void model_step();
    bit c_lvl, c_edge, s_lvl, s_edge, w_lvl, toe;
    if (rst) begin
      hold_left = DRT;
      m_asleep = 0; m_to = 1; m_pd = 1; m_clr = 1; m_wake = 0;
      m_cack = 0; m_sack = 0; m_prev_to = 0; pc = 0; ps = 0;
      qc.delete(); qs.delete(); qw.delete();
      for (int k = 0; k < SYNC; k++) begin
        qc.push_back(1'b0); qs.push_back(1'b0); qw.push_back(1'b0);
      end
      return;
    end
    c_lvl  = qc[0];
    s_lvl  = qs[0];
    w_lvl  = qw[0];
    c_edge = c_lvl && !pc;
    s_edge = s_lvl && !ps;
    toe    = tmo && !m_prev_to && en;

    if (c_edge) m_cack = 1; else if (!c_lvl) m_cack = 0;
    if (s_edge) m_sack = 1; else if (!s_lvl) m_sack = 0;
    m_wake = 0;

    if (hold_left > 0) begin
      hold_left--;
      m_clr = (hold_left > 0);
    end else if (!m_asleep) begin
      if (toe) begin
        m_to = 0; hold_left = DRT; m_clr = 1;
      end else if (s_edge) begin
        m_clr = 1; m_to = 1; m_pd = 0; m_asleep = 1;
      end else if (c_edge) begin
        m_clr = 1; m_to = 1; m_pd = 1;
      end else begin
        m_clr = 0;
      end
    end else begin
      m_clr = 0;
      if (toe) begin
        m_wake = 1; m_to = 0; m_asleep = 0;
      end else if (w_lvl) begin
        m_wake = 1; m_asleep = 0;
      end
    end

    m_prev_to = tmo;
    pc = c_lvl;
    ps = s_lvl;
    void'(qc.pop_front()); qc.push_back(creq);
    void'(qs.pop_front()); qs.push_back(sreq);
    void'(qw.pop_front()); qw.push_back(ewk);
  endfunction

  task automatic step(input string tag);
    logic [7:0] got, exp;
    @(posedge clk_wdt);
    model_step();
    #1;
    got = {cpu_rst, clr, sleeping, wake, sto, spd, cack, sack};
    exp = {(hold_left > 0), m_clr, m_asleep, m_wake, m_to, m_pd, m_cack, m_sack};
    chk(tag, {24'd0, got}, {24'd0, exp});
  endtask

  task automatic steps(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  // Steps until cpu_rst drops (bounded) and checks the observed hold length.
  task automatic measure_hold(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 40 && cpu_rst; k++) begin
      n++;
      step({tag, "_cyc"});
    end
    chk({tag, "_len"}, n, DRT);
  endtask

  task automatic enter_sleep(input string tag);
    sreq = 1; steps(4, tag);
    sreq = 0; steps(3, tag);
  endtask

  initial begin
    int n_clr;
    rst = 1; en = 1; tmo = 0; creq = 0; sreq = 0; ewk = 0;

    // 1: power-on hold
    steps(3, "t1_rst");
    chk("t1_rst_cpu_rst", cpu_rst, 1);
    chk("t1_rst_wdt_clr", clr, 1);
    rst = 0;
    measure_hold("t1_hold");
    chk("t1_to", sto, 1);
    chk("t1_pd", spd, 1);

    // 2: CLRWDT handshake
    creq = 1;
    n_clr = 0;
    for (int k = 0; k < 5; k++) begin
      step("t2_req");
      if (clr) n_clr++;
    end
    chk("t2_clr_pulses", n_clr, 1);
    chk("t2_ack_hi", cack, 1);
    creq = 0; steps(3, "t2_drop");
    chk("t2_ack_lo", cack, 0);

    // 3: enabled timeout resets the core, disabled one is ignored
    tmo = 1; step("t3_toe"); tmo = 0;
    chk("t3_cpu_rst", cpu_rst, 1);
    chk("t3_to", sto, 0);
    chk("t3_pd", spd, 1);
    measure_hold("t3_hold");
    en = 0; tmo = 1; step("t3_dis"); tmo = 0; step("t3_dis");
    chk("t3_dis_cpu_rst", cpu_rst, 0);
    en = 1;

    // 4: timeout while sleeping wakes without reset
    enter_sleep("t4_sleep");
    chk("t4_sleeping", sleeping, 1);
    chk("t4_pd", spd, 0);
    chk("t4_to", sto, 1);
    tmo = 1; step("t4_toe"); tmo = 0;
    chk("t4_wake", wake, 1);
    chk("t4_to_after", sto, 0);
    chk("t4_cpu_rst", cpu_rst, 0);
    step("t4_after");
    chk("t4_wake_pulse", wake, 0);

    // 5: timeout and external wake arriving together; then wake alone
    enter_sleep("t5_sleep");
    ewk = 1; steps(2, "t5_sync");
    tmo = 1; step("t5_both"); tmo = 0;
    chk("t5_both_wake", wake, 1);
    chk("t5_both_to", sto, 0);
    ewk = 0; steps(3, "t5_idle");
    enter_sleep("t5_sleep2");
    ewk = 1; steps(3, "t5_ewk");
    chk("t5_ewk_wake", wake, 1);
    chk("t5_ewk_to", sto, 1);
    chk("t5_ewk_pd", spd, 0);
    ewk = 0; steps(3, "t5_idle");

    // 6: reset mid-HOLD and mid-SLEEP
    tmo = 1; step("t6_toe"); tmo = 0;
    steps(7, "t6_hold");
    rst = 1; step("t6_rst_hold");
    chk("t6_h_cpu_rst", cpu_rst, 1);
    chk("t6_h_to", sto, 1);
    chk("t6_h_pd", spd, 1);
    rst = 0;
    measure_hold("t6_hold_restart");
    sreq = 1; steps(4, "t6_sleep");
    rst = 1; step("t6_rst_sleep");
    chk("t6_s_sleeping", sleeping, 0);
    chk("t6_s_ack", sack, 0);
    chk("t6_s_pd", spd, 1);
    rst = 0; sreq = 0;
    measure_hold("t6_sleep_restart");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if (!tmo) tmo = ($urandom_range(0, 59) == 0);
      else      tmo = ($urandom_range(0, 3) != 0);
      if (!creq && !m_cack && $urandom_range(0, 15) == 0) creq = 1;
      else if (creq && m_cack && $urandom_range(0, 3) == 0) creq = 0;
      if (!sreq && !m_sack && $urandom_range(0, 15) == 0) sreq = 1;
      else if (sreq && m_sack && $urandom_range(0, 3) == 0) sreq = 0;
      if (!ewk) ewk = ($urandom_range(0, 49) == 0);
      else      ewk = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
